// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB).
// Define MCCTRL_MEM_WAIT_EN to stall in MEM until mem_ready is high.
module mc_controller #(
    parameter int IFETCH_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_we,
    output logic       pc_we,
    output logic [2:0] npc_sel,
    output logic [2:0] reg_dst,
    output logic [2:0] mem_to_reg,
    output logic [2:0] alu_ctrl,
    output logic       alu_src,
    output logic       ext_op,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic [2:0] state,
    output logic       instr_done
);
    typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
    typedef enum logic [3:0] {C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL} cls_t;

    localparam logic [3:0] LAST = 4'(IFETCH_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    cls_t       cls;
    logic       mem_go;

`ifdef MCCTRL_MEM_WAIT_EN
    assign mem_go = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign mem_go = 1'b1;
`endif

    assign state = state_q;

    always_comb begin
        cls = C_NOP;
        case (op)
            6'h00: cls = (func == 6'h21) ? C_ADDU : (func == 6'h23) ? C_SUBU : (func == 6'h08) ? C_JR : C_NOP;
            6'h0F: cls = C_LUI;
            6'h0D: cls = C_ORI;
            6'h23: cls = C_LW;
            6'h2B: cls = C_SW;
            6'h04: cls = C_BEQ;
            6'h03: cls = C_JAL;
            default: cls = C_NOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by reset_n so nothing (not even ir_we) shows while reset is held.
    always_comb begin
        state_d    = FETCH;
        cnt_d      = '0;
        ir_we      = 1'b0;
        pc_we      = 1'b0;
        npc_sel    = 3'd0;
        reg_dst    = 3'd0;
        mem_to_reg = 3'd0;
        alu_ctrl   = 3'd0;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        instr_done = 1'b0;
        if (reset_n) begin
            case (state_q)
                FETCH: begin
                    ir_we   = (cnt_q == LAST);
                    state_d = ir_we ? DECODE : FETCH;
                    cnt_d   = ir_we ? 4'd0 : cnt_q + 4'd1;
                end
                DECODE: begin
                    pc_we      = (cls == C_NOP) || (cls == C_JR);
                    instr_done = pc_we;
                    npc_sel    = (cls == C_JR) ? 3'd3 : 3'd0;
                    state_d    = pc_we ? FETCH : (cls == C_JAL) ? WB : EXEC;
                end
                EXEC: begin
                    pc_we      = (cls == C_BEQ);
                    instr_done = pc_we;
                    npc_sel    = (pc_we && zero) ? 3'd1 : 3'd0;
                    state_d    = (cls == C_LW || cls == C_SW) ? MEM :
                                 (cls inside {C_ADDU, C_SUBU, C_ORI, C_LUI}) ? WB : FETCH;
                end
                MEM: begin
                    mem_read   = (cls == C_LW);
                    mem_write  = (cls == C_SW);
                    pc_we      = mem_write && mem_go;
                    instr_done = pc_we;
                    state_d    = !mem_go && (mem_read || mem_write) ? MEM : mem_read ? WB : FETCH;
                end
                WB: begin
                    reg_write  = 1'b1;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    reg_dst    = (cls == C_ADDU || cls == C_SUBU) ? 3'd1 : (cls == C_JAL) ? 3'd2 : 3'd0;
                    mem_to_reg = (cls == C_LW) ? 3'd1 : (cls == C_JAL) ? 3'd2 : (cls == C_LUI) ? 3'd3 : 3'd0;
                    npc_sel    = (cls == C_JAL) ? 3'd2 : 3'd0;
                end
                default: state_d = FETCH;
            endcase
            // ALU controls stay valid from EXEC until the instruction retires.
            if (state_q == EXEC || state_q == MEM || state_q == WB) begin
                alu_ctrl = (cls == C_SUBU || cls == C_BEQ) ? 3'd1 : (cls == C_ORI) ? 3'd2 : 3'd0;
                alu_src  = cls inside {C_ORI, C_LUI, C_LW, C_SW};
                ext_op   = (cls == C_ORI);
            end
        end
    end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: vector table plus scoreboard for mc_controller (F=1 and F=3 instances).
module tb_mc_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, zero, mem_ready;
    logic [5:0] op, func;
    logic       ir_we1, pc_we1, alu_src1, ext_op1, reg_write1, mem_read1, mem_write1, instr_done1;
    logic [2:0] npc_sel1, reg_dst1, mem_to_reg1, alu_ctrl1, state1;
    logic       ir_we3, pc_we3, alu_src3, ext_op3, reg_write3, mem_read3, mem_write3, instr_done3;
    logic [2:0] npc_sel3, reg_dst3, mem_to_reg3, alu_ctrl3, state3;

    mc_controller #(.IFETCH_CYCLES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .ir_we(ir_we1), .pc_we(pc_we1), .npc_sel(npc_sel1), .reg_dst(reg_dst1), .mem_to_reg(mem_to_reg1),
        .alu_ctrl(alu_ctrl1), .alu_src(alu_src1), .ext_op(ext_op1), .reg_write(reg_write1),
        .mem_read(mem_read1), .mem_write(mem_write1), .state(state1), .instr_done(instr_done1));

    mc_controller #(.IFETCH_CYCLES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .ir_we(ir_we3), .pc_we(pc_we3), .npc_sel(npc_sel3), .reg_dst(reg_dst3), .mem_to_reg(mem_to_reg3),
        .alu_ctrl(alu_ctrl3), .alu_src(alu_src3), .ext_op(ext_op3), .reg_write(reg_write3),
        .mem_read(mem_read3), .mem_write(mem_write3), .state(state3), .instr_done(instr_done3));

    logic [22:0] o1, o3;
    assign o1 = {ir_we1, pc_we1, npc_sel1, reg_dst1, mem_to_reg1, alu_ctrl1, alu_src1, ext_op1,
                 reg_write1, mem_read1, mem_write1, state1, instr_done1};
    assign o3 = {ir_we3, pc_we3, npc_sel3, reg_dst3, mem_to_reg3, alu_ctrl3, alu_src3, ext_op3,
                 reg_write3, mem_read3, mem_write3, state3, instr_done3};

    typedef struct {
        string       name;
        logic [5:0]  op, func;
        logic        zero;
        int          cycles;
        logic [19:0] trace;
        int          npc, rw, rdst, m2r, alu, asrc, ext, mw, mrd;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];
    vec_t vecs[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [5:0] o, input logic [5:0] f, input logic z,
                                input int cyc, input logic [19:0] tr, input int npc, input int rw, input int rdst,
                                input int m2r, input int alu, input int asrc, input int ext, input int mw,
                                input int mrd);
        vec_t v;
        v.name = name; v.op = o; v.func = f; v.zero = z; v.cycles = cyc; v.trace = tr;
        v.npc = npc; v.rw = rw; v.rdst = rdst; v.m2r = m2r; v.alu = alu; v.asrc = asrc;
        v.ext = ext; v.mw = mw; v.mrd = mrd;
        return v;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_f1", int'(o1), 0);
        chk("reset_outputs_f3", int'(o3), 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Drives one instruction starting in its first FETCH cycle; result is scored on instr_done.
    task automatic run_vec(input vec_t v);
        int cyc = 0, pcw = 0, irw = 0, mrd = 0, ovl = 0;
        logic [19:0] tr = '0;
        logic done = 1'b0;
        vec_t e;
        op = v.op; func = v.func; zero = v.zero;
        sb.push_back(v);
        while (!done && cyc < 12) begin
            @(negedge clk);
            cyc++;
            tr = {tr[15:0], 1'b0, state1};
            pcw += int'(pc_we1);
            irw += int'(ir_we1);
            mrd += int'(mem_read1);
            ovl += int'(reg_write1 && mem_write1);
            if (instr_done1) begin
                done = 1'b1;
                e = sb.pop_front();
                chk({e.name, "_cycles"}, cyc, e.cycles);
                chk({e.name, "_trace"}, int'(tr), int'(e.trace));
                chk({e.name, "_npc_sel"}, int'(npc_sel1), e.npc);
                chk({e.name, "_reg_write"}, int'(reg_write1), e.rw);
                chk({e.name, "_reg_dst"}, int'(reg_dst1), e.rdst);
                chk({e.name, "_mem_to_reg"}, int'(mem_to_reg1), e.m2r);
                chk({e.name, "_alu_ctrl"}, int'(alu_ctrl1), e.alu);
                chk({e.name, "_alu_src"}, int'(alu_src1), e.asrc);
                chk({e.name, "_ext_op"}, int'(ext_op1), e.ext);
                chk({e.name, "_mem_write"}, int'(mem_write1), e.mw);
                chk({e.name, "_mem_read_cycles"}, mrd, e.mrd);
                chk({e.name, "_pc_we_count"}, pcw, 1);
                chk({e.name, "_ir_we_count"}, irw, 1);
                chk({e.name, "_rw_mw_overlap"}, ovl, 0);
            end else begin
                @(posedge clk);
            end
        end
        chk({v.name, "_instr_done_seen"}, int'(done), 1);
        if (!done) void'(sb.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pcw;
        logic [19:0] tr;
        int irm, pcm;
        vecs[0]  = mk("nop",     6'h00, 6'h00, 1'b0, 2, 20'h01,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk("r_other", 6'h00, 6'h22, 1'b0, 2, 20'h01,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mk("illegal", 6'h3F, 6'h21, 1'b1, 2, 20'h01,    0, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mk("jr",      6'h00, 6'h08, 1'b0, 2, 20'h01,    3, 0, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mk("addu",    6'h00, 6'h21, 1'b0, 4, 20'h0124,  0, 1, 1, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk("subu",    6'h00, 6'h23, 1'b1, 4, 20'h0124,  0, 1, 1, 0, 1, 0, 0, 0, 0);
        vecs[6]  = mk("ori",     6'h0D, 6'h00, 1'b0, 4, 20'h0124,  0, 1, 0, 0, 2, 1, 1, 0, 0);
        vecs[7]  = mk("lui",     6'h0F, 6'h00, 1'b0, 4, 20'h0124,  0, 1, 0, 3, 0, 1, 0, 0, 0);
        vecs[8]  = mk("lw",      6'h23, 6'h00, 1'b0, 5, 20'h01234, 0, 1, 0, 1, 0, 1, 0, 0, 1);
        vecs[9]  = mk("sw",      6'h2B, 6'h00, 1'b0, 4, 20'h0123,  0, 0, 0, 0, 0, 1, 0, 1, 0);
        vecs[10] = mk("beq_t",   6'h04, 6'h00, 1'b1, 3, 20'h012,   1, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[11] = mk("beq_nt",  6'h04, 6'h00, 1'b0, 3, 20'h012,   0, 0, 0, 0, 1, 0, 0, 0, 0);
        vecs[12] = mk("jal",     6'h03, 6'h00, 1'b0, 3, 20'h014,   2, 1, 2, 2, 0, 0, 0, 0, 0);
        vecs[13] = mk("lw_func", 6'h23, 6'h3F, 1'b1, 5, 20'h01234, 0, 1, 0, 1, 0, 1, 0, 0, 1);

        op = 6'h00; func = 6'h00; zero = 1'b0;
`ifdef MCCTRL_MEM_WAIT_EN
        mem_ready = 1'b1;
`else
        mem_ready = 1'b0;
`endif
        do_reset();
        for (int i = 0; i < 14; i++) run_vec(vecs[i]);

        // sw aborted by reset in MEM
        op = 6'h2B; func = 6'h00;
        do_reset();
        repeat (4) @(negedge clk);
        chk("sw_abort_in_mem", int'(state1), 3);
        chk("sw_abort_mem_write_before", int'(mem_write1), 1);
        #1 reset_n = 1'b0;
        #1;
        chk("sw_abort_mem_write_async", int'(mem_write1), 0);
        chk("sw_abort_state_async", int'(state1), 0);
        pcw = 0;
        repeat (2) begin @(negedge clk); pcw += int'(pc_we1); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (3) begin @(negedge clk); pcw += int'(pc_we1) + int'(mem_write1); end
        chk("sw_abort_no_pc_we", pcw, 0);

        // jal with three fetch cycles
        op = 6'h03;
        do_reset();
        tr = '0; irm = 0; pcm = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            tr = {tr[15:0], 1'b0, state3};
            irm |= int'(ir_we3) << c;
            pcm |= int'(pc_we3) << c;
        end
        chk("f3_jal_trace", int'(tr), 'h00014);
        chk("f3_jal_ir_we_cycle", irm, 'b00100);
        chk("f3_jal_pc_we_cycle", pcm, 'b10000);
        chk("f3_jal_reg_dst", int'(reg_dst3), 2);
        chk("f3_jal_mem_to_reg", int'(mem_to_reg3), 2);
        chk("f3_jal_npc_sel", int'(npc_sel3), 2);
        chk("f3_jal_done", int'(instr_done3), 1);

`ifdef MCCTRL_MEM_WAIT_EN
        begin
            int cyc = 0, mrd = 0, memc = 0;
            logic done = 1'b0;
            op = 6'h23; mem_ready = 1'b0;
            do_reset();
            while (!done && cyc < 15) begin
                @(negedge clk);
                cyc++;
                mrd += int'(mem_read1);
                memc += int'(state1 == 3'd3);
                if (instr_done1) begin
                    done = 1'b1;
                    chk("wait_lw_mem_to_reg", int'(mem_to_reg1), 1);
                    chk("wait_lw_state", int'(state1), 4);
                end
                @(posedge clk);
                #1;
                if (memc == 3) mem_ready = 1'b1;
            end
            chk("wait_lw_done_seen", int'(done), 1);
            chk("wait_lw_cycles", cyc, 8);
            chk("wait_lw_mem_read_cycles", mrd, 4);
            mem_ready = 1'b1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
